control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit_if.sv | 40 ++++
 rtl/control_unit.sv | 144 ++++++++++++++
 tb/tb_control_unit.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/control_unit_if.sv
// Control-unit bus: opcode and ALU flags in, microcode control lines and status out.
// master = the control unit, slave = the datapath it steers.
interface control_unit_if;
  logic [3:0] opcode;
  logic       flag_zero;
  logic       flag_carry;
  logic       pc_out;
  logic       pc_inc;
  logic       pc_load;
  logic       mar_load;
  logic       ram_out;
  logic       ram_in;
  logic       ir_load;
  logic       ir_out;
  logic       a_load;
  logic       a_out;
  logic       b_load;
  logic       alu_out;
  logic       alu_sub;
  logic       out_load;
  logic       flags_load;
  logic [2:0] step;
  logic       halted;
  logic       zf;
  logic       cf;

  modport master (
    input  opcode, flag_zero, flag_carry,
    output pc_out, pc_inc, pc_load, mar_load, ram_out, ram_in, ir_load, ir_out,
           a_load, a_out, b_load, alu_out, alu_sub, out_load, flags_load,
           step, halted, zf, cf
  );

  modport slave (
    output opcode, flag_zero, flag_carry,
    input  pc_out, pc_inc, pc_load, mar_load, ram_out, ram_in, ir_load, ir_out,
           a_load, a_out, b_load, alu_out, alu_sub, out_load, flags_load,
           step, halted, zf, cf
  );
endinterface

// File: rtl/control_unit.sv
// Microcoded control unit, T0..T4 steps; CTRL_EARLY_EXIT_EN returns to T0 after each opcode's last step.
// Latency: controls decode combinationally from the current step; step/flags/halted update each clock.
// Backpressure: none; after HLT the sequencer freezes at T2 with all controls low until rst_n.
module control_unit (
  input  logic           clk,
  input  logic           rst_n,
  control_unit_if.master bus
);

  typedef enum logic [2:0] {T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4} step_t;

  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef struct packed {
    logic pc_out;
    logic pc_inc;
    logic pc_load;
    logic mar_load;
    logic ram_out;
    logic ram_in;
    logic ir_load;
    logic ir_out;
    logic a_load;
    logic a_out;
    logic b_load;
    logic alu_out;
    logic alu_sub;
    logic out_load;
    logic flags_load;
  } ctrl_t;

  step_t step_q, step_d;
  logic  halted_q, halted_d;
  logic  zf_q, cf_q;
  ctrl_t ctrl;
  logic  last_step_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q   <= T0;
      halted_q <= 1'b0;
      zf_q     <= 1'b0;
      cf_q     <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
      if (ctrl.flags_load) begin
        zf_q <= bus.flag_zero;
        cf_q <= bus.flag_carry;
      end
    end
  end

`ifdef CTRL_EARLY_EXIT_EN
  logic [2:0] last_step;
  always_comb begin
    case (bus.opcode)
      OP_LDA, OP_STA: last_step = 3'd3;
      OP_ADD, OP_SUB: last_step = 3'd4;
      default:        last_step = 3'd2;
    endcase
    last_step_hit = (3'(step_q) == last_step);
  end
`else
  assign last_step_hit = (step_q == T4);
`endif

  always_comb begin
    ctrl     = '0;
    step_d   = step_q;
    halted_d = halted_q;
    if (!halted_q) begin
      case (step_q)
        T0: begin ctrl.pc_out = 1'b1; ctrl.mar_load = 1'b1; end
        T1: begin ctrl.ram_out = 1'b1; ctrl.ir_load = 1'b1; ctrl.pc_inc = 1'b1; end
        T2: begin
          case (bus.opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin ctrl.ir_out = 1'b1; ctrl.mar_load = 1'b1; end
            OP_LDI: begin ctrl.ir_out = 1'b1; ctrl.a_load  = 1'b1; end
            OP_JMP: begin ctrl.ir_out = 1'b1; ctrl.pc_load = 1'b1; end
            // Conditional jumps look at the latched flags, never the live ALU outputs.
            OP_JC:  begin ctrl.ir_out = 1'b1; ctrl.pc_load = cf_q; end
            OP_JZ:  begin ctrl.ir_out = 1'b1; ctrl.pc_load = zf_q; end
            OP_OUT: begin ctrl.a_out  = 1'b1; ctrl.out_load = 1'b1; end
            default: ;
          endcase
        end
        T3: begin
          case (bus.opcode)
            OP_LDA: begin ctrl.ram_out = 1'b1; ctrl.a_load = 1'b1; end
            OP_ADD: begin ctrl.ram_out = 1'b1; ctrl.b_load = 1'b1; end
            OP_SUB: begin ctrl.ram_out = 1'b1; ctrl.b_load = 1'b1; ctrl.alu_sub = 1'b1; end
            OP_STA: begin ctrl.a_out   = 1'b1; ctrl.ram_in = 1'b1; end
            default: ;
          endcase
        end
        T4: begin
          if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            ctrl.alu_out    = 1'b1;
            ctrl.a_load     = 1'b1;
            ctrl.flags_load = 1'b1;
            ctrl.alu_sub    = (bus.opcode == OP_SUB);
          end
        end
        default: ;
      endcase

      if (step_q == T2 && bus.opcode == OP_HLT) halted_d = 1'b1;
      else if (last_step_hit)                     step_d   = T0;
      else                                        step_d   = step_t'(3'(step_q) + 3'd1);
    end
    if (!rst_n) ctrl = '0;
  end

  assign bus.pc_out     = ctrl.pc_out;
  assign bus.pc_inc     = ctrl.pc_inc;
  assign bus.pc_load    = ctrl.pc_load;
  assign bus.mar_load   = ctrl.mar_load;
  assign bus.ram_out    = ctrl.ram_out;
  assign bus.ram_in     = ctrl.ram_in;
  assign bus.ir_load    = ctrl.ir_load;
  assign bus.ir_out     = ctrl.ir_out;
  assign bus.a_load     = ctrl.a_load;
  assign bus.a_out      = ctrl.a_out;
  assign bus.b_load     = ctrl.b_load;
  assign bus.alu_out    = ctrl.alu_out;
  assign bus.alu_sub    = ctrl.alu_sub;
  assign bus.out_load   = ctrl.out_load;
  assign bus.flags_load = ctrl.flags_load;
  assign bus.step       = 3'(step_q);
  assign bus.halted     = halted_q;
  assign bus.zf         = zf_q;
  assign bus.cf         = cf_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit (default build: every instruction walks T0..T4).
// Per-instruction vector table plus hand sequences for reset, mid-instruction abort and HLT.
module tb_control_unit;

  localparam logic [14:0] C_PC_OUT   = 15'h4000;
  localparam logic [14:0] C_PC_INC   = 15'h2000;
  localparam logic [14:0] C_PC_LOAD  = 15'h1000;
  localparam logic [14:0] C_MAR      = 15'h0800;
  localparam logic [14:0] C_RAM_OUT  = 15'h0400;
  localparam logic [14:0] C_RAM_IN   = 15'h0200;
  localparam logic [14:0] C_IR_LOAD  = 15'h0100;
  localparam logic [14:0] C_IR_OUT   = 15'h0080;
  localparam logic [14:0] C_A_LOAD   = 15'h0040;
  localparam logic [14:0] C_A_OUT    = 15'h0020;
  localparam logic [14:0] C_B_LOAD   = 15'h0010;
  localparam logic [14:0] C_ALU_OUT  = 15'h0008;
  localparam logic [14:0] C_ALU_SUB  = 15'h0004;
  localparam logic [14:0] C_OUT_LOAD = 15'h0002;
  localparam logic [14:0] C_FLAGS    = 15'h0001;
  localparam logic [14:0] C_T0       = C_PC_OUT | C_MAR;
  localparam logic [14:0] C_T1       = C_RAM_OUT | C_IR_LOAD | C_PC_INC;

  typedef struct {
    logic [3:0]  op;
    logic        fz;
    logic        fc;
    logic [14:0] t2;
    logic [14:0] t3;
    logic [14:0] t4;
    logic        zf_after;
    logic        cf_after;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  vec_t vt [13];

  control_unit_if bus ();
  control_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  logic [14:0] ctrl_act;
  assign ctrl_act = {bus.pc_out, bus.pc_inc, bus.pc_load, bus.mar_load, bus.ram_out,
                     bus.ram_in, bus.ir_load, bus.ir_out, bus.a_load, bus.a_out,
                     bus.b_load, bus.alu_out, bus.alu_sub, bus.out_load, bus.flags_load};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] st, input logic [14:0] c,
                         input logic z, input logic cy, input logic h);
    chk({tag, " step"},   32'(bus.step),   32'(st));
    chk({tag, " ctrl"},   32'(ctrl_act),   32'(c));
    chk({tag, " zf"},     32'(bus.zf),     32'(z));
    chk({tag, " cf"},     32'(bus.cf),     32'(cy));
    chk({tag, " halted"}, 32'(bus.halted), 32'(h));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] want_c [5];
    logic        zf_m, cf_m;

    //           op       fz    fc    T2                    T3                               T4                                           zf    cf
    vt[0]  = '{4'b0101, 1'b0, 1'b0, C_IR_OUT | C_A_LOAD,  15'h0,                           15'h0,                                       1'b0, 1'b0}; // LDI
    vt[1]  = '{4'b1000, 1'b1, 1'b0, C_IR_OUT,             15'h0,                           15'h0,                                       1'b0, 1'b0}; // JZ, live fz ignored
    vt[2]  = '{4'b0010, 1'b0, 1'b1, C_IR_OUT | C_MAR,     C_RAM_OUT | C_B_LOAD,            C_ALU_OUT | C_A_LOAD | C_FLAGS,              1'b0, 1'b1}; // ADD
    vt[3]  = '{4'b0111, 1'b1, 1'b0, C_IR_OUT | C_PC_LOAD, 15'h0,                           15'h0,                                       1'b0, 1'b1}; // JC taken on latched cf
    vt[4]  = '{4'b0011, 1'b1, 1'b0, C_IR_OUT | C_MAR,     C_RAM_OUT | C_B_LOAD | C_ALU_SUB, C_ALU_OUT | C_A_LOAD | C_FLAGS | C_ALU_SUB, 1'b1, 1'b0}; // SUB
    vt[5]  = '{4'b1000, 1'b0, 1'b1, C_IR_OUT | C_PC_LOAD, 15'h0,                           15'h0,                                       1'b1, 1'b0}; // JZ taken
    vt[6]  = '{4'b0111, 1'b0, 1'b1, C_IR_OUT,             15'h0,                           15'h0,                                       1'b1, 1'b0}; // JC not taken
    vt[7]  = '{4'b0001, 1'b0, 1'b0, C_IR_OUT | C_MAR,     C_RAM_OUT | C_A_LOAD,            15'h0,                                       1'b1, 1'b0}; // LDA
    vt[8]  = '{4'b0100, 1'b0, 1'b0, C_IR_OUT | C_MAR,     C_A_OUT | C_RAM_IN,              15'h0,                                       1'b1, 1'b0}; // STA
    vt[9]  = '{4'b0110, 1'b0, 1'b0, C_IR_OUT | C_PC_LOAD, 15'h0,                           15'h0,                                       1'b1, 1'b0}; // JMP
    vt[10] = '{4'b1110, 1'b0, 1'b0, C_A_OUT | C_OUT_LOAD, 15'h0,                           15'h0,                                       1'b1, 1'b0}; // OUT
    vt[11] = '{4'b0000, 1'b0, 1'b0, 15'h0,                15'h0,                           15'h0,                                       1'b1, 1'b0}; // NOP
    vt[12] = '{4'b1011, 1'b1, 1'b1, 15'h0,                15'h0,                           15'h0,                                       1'b1, 1'b0}; // undefined

    rst_n          = 1'b0;
    bus.opcode     = 4'b0101;
    bus.flag_zero  = 1'b1;
    bus.flag_carry = 1'b1;

    // Held in reset: T0 decode must be masked.
    @(negedge clk);
    chk_all("reset", 3'd0, 15'h0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    rst_n = 1'b1;

    zf_m = 1'b0;
    cf_m = 1'b0;
    for (int i = 0; i < 13; i++) begin
      want_c[0] = C_T0;
      want_c[1] = C_T1;
      want_c[2] = vt[i].t2;
      want_c[3] = vt[i].t3;
      want_c[4] = vt[i].t4;
      for (int s = 0; s < 5; s++) begin
        bus.opcode     = vt[i].op;
        bus.flag_zero  = vt[i].fz;
        bus.flag_carry = vt[i].fc;
        @(negedge clk);
        chk_all($sformatf("v%0d T%0d", i, s), 3'(s), want_c[s], zf_m, cf_m, 1'b0);
        next_cycle();
      end
      zf_m = vt[i].zf_after;
      cf_m = vt[i].cf_after;
    end
    chk_all("after table", 3'd0, C_T0, 1'b1, 1'b0, 1'b0);

    // Reset in T3 of LDA aborts at once; first cycle after release is T0.
    bus.opcode = 4'b0001;
    next_cycle();
    next_cycle();
    next_cycle();
    chk_all("lda T3", 3'd3, C_RAM_OUT | C_A_LOAD, 1'b1, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk_all("abort", 3'd0, 15'h0, 1'b0, 1'b0, 1'b0);
    bus.opcode = 4'b1111;
    next_cycle();
    chk_all("still reset", 3'd0, 15'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_all("post abort T0", 3'd0, C_T0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    chk_all("hlt T1", 3'd1, C_T1, 1'b0, 1'b0, 1'b0);

    // HLT: T2 asserts nothing, then the unit freezes at step 2.
    next_cycle();
    chk_all("hlt T2", 3'd2, 15'h0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    chk_all("halted", 3'd2, 15'h0, 1'b0, 1'b0, 1'b1);
    bus.opcode     = 4'b0010;
    bus.flag_zero  = 1'b1;
    bus.flag_carry = 1'b1;
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      chk_all($sformatf("halt hold %0d", k), 3'd2, 15'h0, 1'b0, 1'b0, 1'b1);
    end

    #2 rst_n = 1'b0;
    #1;
    chk_all("halt reset", 3'd0, 15'h0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk_all("restart T0", 3'd0, C_T0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    chk_all("restart T1", 3'd1, C_T1, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
